// File: rtl/tone_gen.sv
// tone_gen: turns a held key (note code) into a 50% square wave.
// Half-period lengths are counted in tick_1M strobes; note changes and
// note-off only take effect when a full period (HIGH then LOW) has ended.
module tone_gen #(
  parameter int CNT_W        = 11,
  parameter int OCTAVE_SHIFT = 0
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       tick_1M,
  input  logic       note_on,
  input  logic [3:0] note_code,
  output logic       audio_out,
  output logic       active,
  output logic [3:0] cur_code
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] half, half_next;
  logic [3:0]       code_next;
  logic [10:0]      shifted_half;
  logic [CNT_W-1:0] table_half;
  logic             go;
  logic             last_tick;

  // Unshifted half-period in ticks for C4..C5; invalid codes give zero,
  // but they never reach the latch because go is low for them.
  function automatic logic [10:0] base_half(input logic [3:0] code);
    case (code)
      4'd0:    base_half = 11'd1911;
      4'd1:    base_half = 11'd1804;
      4'd2:    base_half = 11'd1703;
      4'd3:    base_half = 11'd1607;
      4'd4:    base_half = 11'd1517;
      4'd5:    base_half = 11'd1432;
      4'd6:    base_half = 11'd1351;
      4'd7:    base_half = 11'd1276;
      4'd8:    base_half = 11'd1204;
      4'd9:    base_half = 11'd1136;
      4'd10:   base_half = 11'd1073;
      4'd11:   base_half = 11'd1012;
      4'd12:   base_half = 11'd956;
      default: base_half = 11'd0;
    endcase
  endfunction

  assign go           = note_on && (note_code <= 4'd12);
  assign shifted_half = base_half(note_code) >> OCTAVE_SHIFT;
  assign table_half   = CNT_W'(shifted_half);
  // The tick that consumes the final count of the current phase.
  assign last_tick    = tick_1M && (cnt == CNT_W'(1));

  // Next-state logic: counts ticks within a phase, re-latches the note at
  // the start of every period so mid-period changes wait for the boundary.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    half_next  = half;
    code_next  = cur_code;
    case (state)
      IDLE: begin
        if (go) begin
          state_next = HIGH;
          code_next  = note_code;
          half_next  = table_half;
          cnt_next   = table_half;
        end
      end
      HIGH: begin
        if (last_tick) begin
          state_next = LOW;
          cnt_next   = half;
        end else if (tick_1M) begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (last_tick) begin
          if (go) begin
            state_next = HIGH;
            code_next  = note_code;
            half_next  = table_half;
            cnt_next   = table_half;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else if (tick_1M) begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and datapath registers; outputs are registered from the next
  // state so audio_out is glitch-free and rises one cycle after go.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      half      <= '0;
      cur_code  <= 4'd0;
      audio_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      half      <= half_next;
      cur_code  <= code_next;
      audio_out <= (state_next == HIGH);
      active    <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Testbench for tone_gen: a monitor measures each completed period of the
// square wave and compares it against periods queued when keys are driven.
module tb_tone_gen;

  typedef struct {
    int hi;
    int lo;
    int code;
  } period_t;

  logic       clk_100M = 1'b0;
  logic       rst      = 1'b1;
  logic       tick     = 1'b1;
  logic       note_on  = 1'b0;
  logic [3:0] note_code = 4'd0;
  logic       audio_out, active;
  logic [3:0] cur_code;

  // Second instance: octave-shifted, driven by a sparse tick.
  logic       tick1     = 1'b0;
  logic       note_on1  = 1'b0;
  logic [3:0] note_code1 = 4'd0;
  logic       audio_out1, active1;
  logic [3:0] cur_code1;

  int checks = 0;
  int errors = 0;
  period_t sb[$];

  tone_gen #(.CNT_W(11), .OCTAVE_SHIFT(0)) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .tick_1M  (tick),
    .note_on  (note_on),
    .note_code(note_code),
    .audio_out(audio_out),
    .active   (active),
    .cur_code (cur_code)
  );

  tone_gen #(.CNT_W(11), .OCTAVE_SHIFT(1)) dut1 (
    .clk_100M (clk_100M),
    .rst      (rst),
    .tick_1M  (tick1),
    .note_on  (note_on1),
    .note_code(note_code1),
    .audio_out(audio_out1),
    .active   (active1),
    .cur_code (cur_code1)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Tick every 5th cycle for the second instance.
  initial begin
    int tc = 0;
    forever begin
      @(negedge clk_100M);
      tc++;
      tick1 = (tc % 5 == 0);
    end
  end

  // Monitor: measure high/low lengths of each period and pop the scoreboard.
  initial begin
    int  hcnt = 0, lcnt = 0, pcode = 0;
    logic pa = 1'b0, pact = 1'b0;
    period_t e;
    forever begin
      @(negedge clk_100M);
      if (rst) begin
        hcnt = 0; lcnt = 0;
      end else begin
        if (lcnt > 0 && ((!pa && audio_out) || (pact && !active))) begin
          if (sb.size() == 0) begin
            chk("unexpected_period", hcnt, -1);
          end else begin
            e = sb.pop_front();
            $display("period: high=%0d low=%0d code=%0d (exp %0d/%0d/%0d)",
                     hcnt, lcnt, pcode, e.hi, e.lo, e.code);
            chk("period_high", hcnt, e.hi);
            chk("period_low", lcnt, e.lo);
            chk("period_code", pcode, e.code);
          end
          hcnt = 0; lcnt = 0;
        end
        if (audio_out) begin
          hcnt++;
          if (hcnt == 1) pcode = int'(cur_code);
        end else if (active) begin
          lcnt++;
        end
      end
      pa   = audio_out;
      pact = active;
    end
  end

  task automatic push(input int hi, input int lo, input int code);
    period_t p;
    p.hi = hi; p.lo = lo; p.code = code;
    sb.push_back(p);
  endtask

  task automatic wait_rise(input string tag);
    logic p = audio_out;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk_100M);
      if (!p && audio_out) return;
      p = audio_out;
    end
    chk(tag, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk_100M);
      if (!active) return;
    end
    chk(tag, 0, 1);
  endtask

  initial begin
    int len;
    // Reset state.
    repeat (3) @(negedge clk_100M);
    chk("reset_audio", audio_out, 0);
    chk("reset_active", active, 0);
    chk("reset_code", cur_code, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk_100M);

    // Steady note 9: one-cycle latency, then 1136/1136.
    note_code = 4'd9; note_on = 1'b1;
    push(1136, 1136, 9); push(1136, 1136, 9); push(1136, 1136, 9);
    @(negedge clk_100M);
    chk("latency_audio", audio_out, 1);
    chk("latency_active", active, 1);
    chk("latency_code", cur_code, 9);
    wait_rise("rise_p2_timeout");
    wait_rise("rise_p3_timeout");

    // Code change mid-HIGH applies only at the next period.
    repeat (300) @(negedge clk_100M);
    note_code = 4'd12;
    push(956, 956, 12);
    @(negedge clk_100M);
    chk("code_held_mid_period", cur_code, 9);
    wait_rise("rise_p4_timeout");
    chk("code_new_period", cur_code, 12);

    // Note-off mid-HIGH: period completes, then IDLE.
    repeat (10) @(negedge clk_100M);
    note_on = 1'b0;
    @(negedge clk_100M);
    chk("noteoff_still_high", audio_out, 1);
    wait_idle("idle_timeout");
    chk("idle_audio", audio_out, 0);
    chk("idle_code_held", cur_code, 12);

    // Invalid code behaves as silence; then code 0 plays.
    note_code = 4'd14; note_on = 1'b1;
    repeat (50) @(negedge clk_100M);
    chk("invalid_audio", audio_out, 0);
    chk("invalid_active", active, 0);
    note_code = 4'd0;
    push(1911, 1911, 0);
    wait_rise("rise_c0_timeout");
    chk("c0_code", cur_code, 0);
    wait_rise("rise_c0b_timeout");

    // Asynchronous reset mid-HIGH.
    repeat (100) @(negedge clk_100M);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_audio", audio_out, 0);
    chk("async_rst_active", active, 0);
    chk("async_rst_code", cur_code, 0);
    note_on = 1'b0;
    @(negedge clk_100M);
    rst = 1'b0;
    repeat (20) @(negedge clk_100M);
    chk("post_rst_idle", active, 0);
    chk("sb_empty", sb.size(), 0);

    // Sparse tick, OCTAVE_SHIFT=1, code 12: half = 478 ticks of 5 cycles.
    note_code1 = 4'd12; note_on1 = 1'b1;
    len = 0;
    while (!audio_out1 && len < 1000) begin @(negedge clk_100M); len++; end
    chk("sparse_rise", audio_out1, 1);
    len = 0;
    while (audio_out1 && len < 5000) begin @(negedge clk_100M); len++; end
    $display("sparse high1=%0d", len);
    chk("sparse_high1_range", int'(len >= 477*5+1 && len <= 478*5), 1);
    len = 0;
    while (!audio_out1 && len < 5000) begin @(negedge clk_100M); len++; end
    $display("sparse low1=%0d", len);
    chk("sparse_low1", len, 2390);
    note_on1 = 1'b0;
    len = 0;
    while (audio_out1 && len < 5000) begin @(negedge clk_100M); len++; end
    $display("sparse high2=%0d", len);
    chk("sparse_high2", len, 2390);
    len = 0;
    while (active1 && len < 5000) begin @(negedge clk_100M); len++; end
    $display("sparse low2=%0d", len);
    chk("sparse_low2", len, 2390);
    chk("sparse_idle_audio", audio_out1, 0);
    chk("sparse_code", cur_code1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
